pcie_contador_salidas: RTL

//  Downstream observer for the 4 output FIFOs of the PCIE datapath (data_out4..7 side).

---
 rtl/pcie_contador_salidas.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pcie_contador_salidas.sv
// pcie_contador_salidas: counts qualified pops on the four output FIFOs
// (data_out4..7 side) and answers idle-gated read requests with a count.
//
// Ports:
//   clk      : single clock, rising edge
//   reset    : synchronous, active-low
//   init     : synchronous clear of all counters; also cancels a request
//   pop      : pop strobes to FIFOs 4..7 (bit0 = FIFO4)
//   empty    : empty flags of those FIFOs
//   idle     : flow-control FSM is in IDLE
//   req      : read request
//   idx      : 0..3 = FIFO4..7 count, 4 = total, 5..7 = invalid
//   valid    : one-cycle pulse qualifying data
//   data     : requested count, zero-extended to ANCHO_CONTADOR+2 bits
//   idx_err  : one-cycle pulse for an idle request with idx 5..7
//
// Build option: CONT_CLEAR_ON_READ_EN makes accepted reads clear the
// counter(s) they return (idx 4 clears all four).
module pcie_contador_salidas #(
    parameter int NUM_SALIDAS    = 4,
    parameter int ANCHO_CONTADOR = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [NUM_SALIDAS-1:0]    pop,
    input  logic [NUM_SALIDAS-1:0]    empty,
    input  logic                      idle,
    input  logic                      req,
    input  logic [2:0]                idx,
    output logic                      valid,
    output logic [ANCHO_CONTADOR+1:0] data,
    output logic                      idx_err
);

    localparam int DW = ANCHO_CONTADOR + 2;
    localparam logic [ANCHO_CONTADOR-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic                      valid_q, valid_d;
    logic                      idx_err_q, idx_err_d;
    logic [DW-1:0]             data_q, data_d;
    logic [ANCHO_CONTADOR-1:0] cnt_q [NUM_SALIDAS];
    logic [ANCHO_CONTADOR-1:0] cnt_d [NUM_SALIDAS];

    logic [NUM_SALIDAS-1:0]    qual;
    logic [NUM_SALIDAS-1:0]    clr_rd;
    logic                      idx_ok;
    logic                      req_live;
    logic                      accept;
    logic                      bad_idx;
    logic [DW-1:0]             total;
    logic [DW-1:0]             sel;
    logic [ANCHO_CONTADOR-1:0] base;

    // Request decode. Requests are only looked at in ST_IDLE with the
    // flow-control FSM idle; init takes priority over any request.
    always_comb begin
        qual     = pop & ~empty;
        idx_ok   = (idx <= 3'd4);
        req_live = (state_q == ST_IDLE) & req & idle & ~init;
        accept   = req_live & idx_ok;
        bad_idx  = req_live & ~idx_ok;
    end

    // Total is formed two bits wider than a counter, so four saturated
    // counters still fit without overflow.
    always_comb begin
        total = '0;
        for (int i = 0; i < NUM_SALIDAS; i++) begin
            total = total + DW'(cnt_q[i]);
        end
    end

    // Snapshot of the pre-pop counter values; idx[2] only reaches here
    // as idx==4 because idx 5..7 never gets accepted.
    always_comb begin
        if (idx[2]) begin
            sel = total;
        end else begin
            sel = DW'(cnt_q[idx[1:0]]);
        end
    end

    // Which counters an accepted read clears.
    always_comb begin
        clr_rd = '0;
`ifdef CONT_CLEAR_ON_READ_EN
        for (int i = 0; i < NUM_SALIDAS; i++) begin
            clr_rd[i] = accept & (idx[2] | (idx[1:0] == 2'(i)));
        end
`endif
    end

    // Counter next-state: init wins, then read-clear, then a saturating
    // increment on top of whatever base survived. A pop in a clearing
    // read cycle therefore leaves the counter at 1.
    always_comb begin
        base = '0;
        for (int i = 0; i < NUM_SALIDAS; i++) begin
            base = clr_rd[i] ? '0 : cnt_q[i];
            if (init) begin
                cnt_d[i] = '0;
            end else if (qual[i] && (base != CNT_MAX)) begin
                cnt_d[i] = base + 1'b1;
            end else begin
                cnt_d[i] = base;
            end
        end
    end

    // Response FSM and registered outputs next-state.
    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        idx_err_d = 1'b0;
        data_d    = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RESP;
                    valid_d = 1'b1;
                    data_d  = sel;
                end
                idx_err_d = bad_idx;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            idx_err_q <= 1'b0;
            data_q    <= '0;
            for (int i = 0; i < NUM_SALIDAS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            idx_err_q <= idx_err_d;
            data_q    <= data_d;
            for (int i = 0; i < NUM_SALIDAS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign valid   = valid_q;
    assign idx_err = idx_err_q;
    assign data    = data_q;

endmodule
